transpose_collect_fifo: RTL and testbench

- Serial-in, parallel-out row collector at the drain side of the systolic array.
- Accepts one BITS-wide element per cycle from an array output lane.
- Assembles DEPTH consecutive elements into a row and presents the row on a parallel bus under a valid/ready handshake.
- A one-row holding register lets collection of the next row overlap with a stalled consumer. Flush completes a partial row with zero padding.

---
 rtl/transpose_collect_fifo.sv | 77 +++++++
 tb/tb_transpose_collect_fifo.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/transpose_collect_fifo.sv
// Serial-in, parallel-out row collector: gathers DEPTH elements from one array
// output lane into a row and hands it off through a one-row holding register.
module transpose_collect_fifo #(
  parameter int DEPTH = 8,
  parameter int BITS  = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       en,
  input  logic [BITS-1:0]            Cin,
  output logic                       in_ready,
  input  logic                       flush,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [BITS-1:0]            Cout [DEPTH],
  output logic [$clog2(DEPTH+1)-1:0] fill_cnt
);

  localparam int CW = $clog2(DEPTH+1);

  logic [BITS-1:0] buf_q    [DEPTH];
  logic [BITS-1:0] row_next [DEPTH];
  logic            accept;
  logic            drain;
  logic            hold_free;
  logic            last_slot;
  logic            load;

  // NOTE: every signal written here gets a value on every path, so no latches form.
  always_comb begin
    drain     = out_valid && out_ready;
    hold_free = !out_valid || drain;
    last_slot = (fill_cnt == CW'(DEPTH-1));
    // Only the row-completing element waits for the holding register.
    in_ready  = !last_slot || hold_free;
    accept    = en && in_ready;
    load      = (accept && last_slot) ||
                (flush && hold_free && ((fill_cnt != '0) || accept));
    // Unfilled slots are already zero, which provides the flush padding.
    for (int k = 0; k < DEPTH; k++) begin
      row_next[k] = (accept && (fill_cnt == CW'(k))) ? Cin : buf_q[k];
    end
  end

  // NOTE: non-blocking assignments keep all state updates ordered to the clock edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fill_cnt  <= '0;
      out_valid <= 1'b0;
      // NOTE: the row storage is reset because Cout must read as zeros after reset.
      for (int k = 0; k < DEPTH; k++) begin
        buf_q[k] <= '0;
        Cout[k]  <= '0;
      end
    end else if (load) begin
      Cout      <= row_next;
      out_valid <= 1'b1;
      fill_cnt  <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        buf_q[k] <= '0;
      end
    end else begin
      if (drain) begin
        out_valid <= 1'b0;
      end
      if (accept) begin
        for (int k = 0; k < DEPTH; k++) begin
          if (fill_cnt == CW'(k)) begin
            buf_q[k] <= Cin;
          end
        end
        fill_cnt <= fill_cnt + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_transpose_collect_fifo.sv
// Directed bench for transpose_collect_fifo: expected rows are queued as stimulus
// is driven and compared whenever the consumer takes a row.
module tb_transpose_collect_fifo;

  localparam int DEPTH = 8;
  localparam int BITS  = 8;
  localparam int CW    = $clog2(DEPTH+1);

  logic            clk = 1'b0;
  logic            rst_n;
  logic            en;
  logic [BITS-1:0] Cin;
  logic            in_ready;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic [BITS-1:0] Cout [DEPTH];
  logic [CW-1:0]   fill_cnt;

  logic [DEPTH*BITS-1:0] cout_flat;
  logic [DEPTH*BITS-1:0] exp_q [$];
  int checks = 0;
  int errors = 0;

  transpose_collect_fifo #(.DEPTH(DEPTH), .BITS(BITS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .Cin       (Cin),
    .in_ready  (in_ready),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Cout      (Cout),
    .fill_cnt  (fill_cnt)
  );

  always #5 clk = ~clk;

  always_comb begin
    cout_flat = '0;
    for (int k = 0; k < DEPTH; k++) cout_flat[k*BITS +: BITS] = Cout[k];
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [DEPTH*BITS-1:0] mkrow(input logic [7:0] e0, e1, e2, e3,
                                                  e4, e5, e6, e7);
    return {e7, e6, e5, e4, e3, e2, e1, e0};
  endfunction

  // Inputs are set at posedge+1; compare at posedge+3, then advance one edge.
  task automatic tick();
    logic [DEPTH*BITS-1:0] e;
    #2;
    if (out_valid && out_ready) begin
      chk("sb_nonempty", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("row", 64'(cout_flat), 64'(e));
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; Cin = '0; flush = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_fill_cnt",  64'(fill_cnt),  64'd0);
    chk("rst_in_ready",  64'(in_ready),  64'd1);
    chk("rst_cout",      64'(cout_flat), 64'd0);

    // Plain row 1..8 with a ready consumer.
    out_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      en = 1'b1; Cin = 8'(i + 1);
      chk("t1_fill_cnt", 64'(fill_cnt), 64'(i));
      if (i == DEPTH-1) exp_q.push_back(mkrow(1, 2, 3, 4, 5, 6, 7, 8));
      tick();
    end
    en = 1'b0;
    chk("t1_out_valid", 64'(out_valid), 64'd1);
    chk("t1_fill_wrap", 64'(fill_cnt),  64'd0);
    tick();
    chk("t1_one_cycle", 64'(out_valid), 64'd0);

    // Stalled consumer: 16 elements, last one back-pressured.
    out_ready = 1'b0;
    exp_q.push_back(mkrow(10, 11, 12, 13, 14, 15, 16, 17));
    for (int i = 0; i < 15; i++) begin
      en = 1'b1; Cin = 8'(10 + i);
      #1;
      chk("t2_in_ready", 64'(in_ready), 64'd1);
      tick();
    end
    Cin = 8'd25;
    #1;
    chk("t2_stall_ready", 64'(in_ready), 64'd0);
    chk("t2_stall_fill",  64'(fill_cnt), 64'd7);
    tick();
    chk("t2_hold_valid", 64'(out_valid), 64'd1);
    chk("t2_hold_fill",  64'(fill_cnt),  64'd7);
    chk("t2_hold_row",   64'(cout_flat), 64'(mkrow(10, 11, 12, 13, 14, 15, 16, 17)));
    out_ready = 1'b1;
    #1;
    chk("t2_release_ready", 64'(in_ready), 64'd1);
    exp_q.push_back(mkrow(18, 19, 20, 21, 22, 23, 24, 25));
    tick();
    en = 1'b0;
    chk("t2_no_bubble", 64'(out_valid), 64'd1);
    chk("t2_fill_zero", 64'(fill_cnt),  64'd0);
    tick();
    chk("t2_drained", 64'(out_valid), 64'd0);

    // Partial row closed by flush with no accept.
    out_ready = 1'b0;
    en = 1'b1; Cin = 8'hA1; tick();
    Cin = 8'hA2; tick();
    Cin = 8'hA3; tick();
    en = 1'b0; flush = 1'b1;
    exp_q.push_back(mkrow(8'hA1, 8'hA2, 8'hA3, 0, 0, 0, 0, 0));
    tick();
    flush = 1'b0;
    chk("t3_out_valid", 64'(out_valid), 64'd1);
    chk("t3_fill_cnt",  64'(fill_cnt),  64'd0);
    chk("t3_row_held",  64'(cout_flat), 64'(mkrow(8'hA1, 8'hA2, 8'hA3, 0, 0, 0, 0, 0)));
    out_ready = 1'b1;
    tick();

    // Flush on an empty buffer is a no-op.
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("t4_out_valid", 64'(out_valid), 64'd0);
    chk("t4_fill_cnt",  64'(fill_cnt),  64'd0);

    // Flush together with an accept includes that element.
    en = 1'b1; Cin = 8'h11; tick();
    Cin = 8'h22; tick();
    Cin = 8'h55; flush = 1'b1;
    exp_q.push_back(mkrow(8'h11, 8'h22, 8'h55, 0, 0, 0, 0, 0));
    tick();
    en = 1'b0; flush = 1'b0;
    chk("t5_out_valid", 64'(out_valid), 64'd1);
    chk("t5_fill_cnt",  64'(fill_cnt),  64'd0);
    tick();
    chk("t5_drained", 64'(out_valid), 64'd0);

    // Flush blocked by an occupied holding register, applied on the drain cycle.
    out_ready = 1'b0;
    exp_q.push_back(mkrow(8'h61, 8'h62, 8'h63, 8'h64, 8'h65, 8'h66, 8'h67, 8'h68));
    for (int i = 0; i < DEPTH; i++) begin
      en = 1'b1; Cin = 8'(8'h61 + i); tick();
    end
    Cin = 8'h31; tick();
    Cin = 8'h32; tick();
    en = 1'b0; flush = 1'b1;
    tick();
    chk("t6_blocked_fill",  64'(fill_cnt),  64'd2);
    chk("t6_blocked_valid", 64'(out_valid), 64'd1);
    out_ready = 1'b1;
    exp_q.push_back(mkrow(8'h31, 8'h32, 0, 0, 0, 0, 0, 0));
    tick();
    flush = 1'b0;
    chk("t6_flush_valid", 64'(out_valid), 64'd1);
    chk("t6_flush_fill",  64'(fill_cnt),  64'd0);
    tick();
    chk("t6_drained", 64'(out_valid), 64'd0);

    // Reset with a held row and a partial row pending.
    out_ready = 1'b0;
    for (int i = 0; i < DEPTH + 5; i++) begin
      en = 1'b1; Cin = 8'(8'hC0 + i); tick();
    end
    chk("t7_pre_fill",  64'(fill_cnt),  64'd5);
    chk("t7_pre_valid", 64'(out_valid), 64'd1);
    rst_n = 1'b0; Cin = 8'hEE; flush = 1'b1;
    tick();
    rst_n = 1'b1; en = 1'b0; flush = 1'b0;
    #1;
    chk("t7_rst_valid", 64'(out_valid), 64'd0);
    chk("t7_rst_fill",  64'(fill_cnt),  64'd0);
    chk("t7_rst_ready", 64'(in_ready),  64'd1);
    out_ready = 1'b1;
    exp_q.push_back(mkrow(8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h46, 8'h47, 8'h48));
    for (int i = 0; i < DEPTH; i++) begin
      en = 1'b1; Cin = 8'(8'h41 + i); tick();
    end
    en = 1'b0;
    chk("t7_post_valid", 64'(out_valid), 64'd1);
    tick();
    chk("t7_post_drained", 64'(out_valid), 64'd0);

    chk("sb_empty", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
